// File: rtl/rgbw_pkg.sv
// rgbw_pkg -- shared constants and frame FSM states for the RGBW lamp driver.
// Rev 1.0
`default_nettype none

package rgbw_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'h55;
  localparam logic [7:0] TRAILER_BYTE = 8'hA4;
  localparam int         FRAME_LEN    = 8;

  localparam logic [2:0] IDX_MODE    = 3'd1;
  localparam logic [2:0] IDX_RED     = 3'd2;
  localparam logic [2:0] IDX_GREEN   = 3'd3;
  localparam logic [2:0] IDX_BLUE    = 3'd4;
  localparam logic [2:0] IDX_WHITE   = 3'd5;
  localparam logic [2:0] IDX_RSVD    = 3'd6;
  localparam logic [2:0] IDX_TRAILER = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/rgbw_spi_rx.sv
// rgbw_spi_rx -- mode-1 SPI slave byte receiver, oversampled in the clk domain.
// Rev 1.0
`default_nettype none

module rgbw_spi_rx (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       cs_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       abort_o
);

  logic [1:0] sck_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] cs_sync_q;
  logic       sck_prev_q;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       abort_q, abort_d;
  logic       sck_fall;

  // mosi and sck share the same synchronizer depth so they stay aligned
  assign sck_fall = sck_prev_q & ~sck_sync_q[1];

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    abort_d   = 1'b0;
    if (cs_sync_q[1]) begin
      bit_cnt_d = 3'd0;
      abort_d   = (bit_cnt_q != 3'd0);
    end else if (sck_fall) begin
      shift_d   = {shift_q[5:0], mosi_sync_q[1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_d  = {shift_q, mosi_sync_q[1]};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sck_prev_q  <= 1'b0;
      shift_q     <= 7'd0;
      bit_cnt_q   <= 3'd0;
      byte_q      <= 8'd0;
      valid_q     <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      cs_sync_q   <= {cs_sync_q[0], cs_i};
      sck_prev_q  <= sck_sync_q[1];
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      abort_q     <= abort_d;
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign abort_o = abort_q;

endmodule

`default_nettype wire

// File: rtl/rgbw_lamp_ctrl.sv
// rgbw_lamp_ctrl -- SPI-framed four-channel PWM lamp driver with power enables.
// Rev 1.0
`default_nettype none

module rgbw_lamp_ctrl
  import rgbw_pkg::*;
#(
  parameter int PWM_PRESCALE = 1
) (
  input  logic clk12,
  input  logic reset,
  input  logic sck0,
  input  logic mosi,
  input  logic cs,
  output logic red_pin,
  output logic green_pin,
  output logic blue_pin,
  output logic white_pin,
  output logic red_pwr,
  output logic green_pwr,
  output logic blue_pwr,
  output logic white_pwr,
  output logic dbg
);

  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic            rx_abort;

  frame_state_e    state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:1][7:0] stage_q, stage_d;
  logic            trailer_ok_q, trailer_ok_d;
  logic [3:0][7:0] shadow_q, shadow_d;
  logic            dbg_q, dbg_d;

  logic [PW-1:0]   presc_q;
  logic [7:0]      cnt_q;
  logic [3:0][7:0] active_q;
  logic            pwm_step;
  logic            pwm_wrap;
  logic [3:0]      pin_w;
  logic [3:0]      pwr_w;

  rgbw_spi_rx u_spi_rx (
    .clk_i   (clk12),
    .rst_ni  (reset),
    .sck_i   (sck0),
    .mosi_i  (mosi),
    .cs_i    (cs),
    .byte_o  (rx_byte),
    .valid_o (rx_valid),
    .abort_o (rx_abort)
  );

  // A byte cut short by cs drops the whole frame so a re-sent frame starts clean
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    stage_d      = stage_q;
    trailer_ok_d = trailer_ok_q;
    shadow_d     = shadow_q;
    dbg_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = COLLECT;
          idx_d   = IDX_MODE;
        end
      end
      COLLECT: begin
        if (rx_abort) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          if (idx_q == IDX_TRAILER) begin
            trailer_ok_d = (rx_byte == TRAILER_BYTE);
            state_d      = CHECK;
          end else begin
            stage_d[idx_q] = rx_byte;
            idx_d          = idx_q + 3'd1;
          end
        end
      end
      CHECK: begin
        if (trailer_ok_q) begin
          shadow_d[0] = stage_q[IDX_RED];
          shadow_d[1] = stage_q[IDX_GREEN];
          shadow_d[2] = stage_q[IDX_BLUE];
          shadow_d[3] = stage_q[IDX_WHITE];
          dbg_d       = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      stage_q      <= '0;
      trailer_ok_q <= 1'b0;
      shadow_q     <= '0;
      dbg_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      trailer_ok_q <= trailer_ok_d;
      shadow_q     <= shadow_d;
      dbg_q        <= dbg_d;
    end
  end

  assign pwm_step = (presc_q == PW'(PWM_PRESCALE - 1));
  assign pwm_wrap = pwm_step && (cnt_q == 8'hFF);

  // Duties change only at wrap so a PWM period never mixes old and new values
  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      cnt_q    <= 8'd0;
      active_q <= '0;
    end else begin
      presc_q <= pwm_step ? '0 : presc_q + PW'(1);
      if (pwm_step) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (pwm_wrap) begin
        active_q <= shadow_q;
      end
    end
  end

  for (genvar ch = 0; ch < 4; ch++) begin : g_channel
    assign pin_w[ch] = (cnt_q < active_q[ch]);
    assign pwr_w[ch] = (active_q[ch] != 8'd0);
  end

  assign red_pin   = pin_w[0];
  assign green_pin = pin_w[1];
  assign blue_pin  = pin_w[2];
  assign white_pin = pin_w[3];
  assign red_pwr   = pwr_w[0];
  assign green_pwr = pwr_w[1];
  assign blue_pwr  = pwr_w[2];
  assign white_pwr = pwr_w[3];
  assign dbg       = dbg_q;

endmodule

`default_nettype wire

// File: tb/tb_rgbw_lamp_ctrl.sv
// tb_rgbw_lamp_ctrl -- scoreboard bench for the RGBW lamp driver.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_rgbw_lamp_ctrl;

  logic clk12 = 1'b0;
  logic reset = 1'b0;
  logic sck0  = 1'b0;
  logic mosi  = 1'b0;
  logic cs    = 1'b1;
  logic red_pin, green_pin, blue_pin, white_pin;
  logic red_pwr, green_pwr, blue_pwr, white_pwr;
  logic dbg;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int             dbg_pulses;
    logic [3:0][7:0] duty;
  } exp_t;

  exp_t sb[$];

  int         dbg_cnt = 0;
  int         hi_cnt [4];
  logic [3:0] pwr_smp;

  always #5 clk12 = ~clk12;

  rgbw_lamp_ctrl #(.PWM_PRESCALE(1)) dut (
    .clk12     (clk12),
    .reset     (reset),
    .sck0      (sck0),
    .mosi      (mosi),
    .cs        (cs),
    .red_pin   (red_pin),
    .green_pin (green_pin),
    .blue_pin  (blue_pin),
    .white_pin (white_pin),
    .red_pwr   (red_pwr),
    .green_pwr (green_pwr),
    .blue_pwr  (blue_pwr),
    .white_pwr (white_pwr),
    .dbg       (dbg)
  );

  always @(negedge clk12) if (dbg === 1'b1) dbg_cnt++;

  task automatic send_bits(input logic [7:0] b, input int n);
    @(posedge clk12); #1;
    cs = 1'b0;
    repeat (3) @(posedge clk12);
    for (int i = 0; i < n; i++) begin
      #1; mosi = b[7-i]; sck0 = 1'b1;
      repeat (2) @(posedge clk12);
      #1; sck0 = 1'b0;
      repeat (2) @(posedge clk12);
    end
    repeat (2) @(posedge clk12);
    #1; cs = 1'b1;
    repeat (4) @(posedge clk12);
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send_bits(f[63-8*i -: 8], 8);
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk12);
      if (red_pin   === 1'b1) hi_cnt[0]++;
      if (green_pin === 1'b1) hi_cnt[1]++;
      if (blue_pin  === 1'b1) hi_cnt[2]++;
      if (white_pin === 1'b1) hi_cnt[3]++;
    end
    pwr_smp = {white_pwr, blue_pwr, green_pwr, red_pwr};
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    repeat (10) @(posedge clk12);
    @(negedge clk12);
    tests_run++;
    if ({red_pin, green_pin, blue_pin, white_pin, red_pwr, green_pwr, blue_pwr, white_pwr, dbg} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {red_pin, green_pin, blue_pin, white_pin, red_pwr, green_pwr, blue_pwr, white_pwr, dbg});
    end
    #1; reset = 1'b1;
    e.dbg_pulses = 0; e.duty = '0;
    sb.push_back(e);
    measure(1000);
    e = sb.pop_front();
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (hi_cnt[c] !== 0) begin
        tests_failed++;
        $display("FAIL reset_pwm_ch%0d: high for %0d cycles, want 0", c, hi_cnt[c]);
      end
    end
    tests_run++;
    if (pwr_smp !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_pwr: got %b want 0000", pwr_smp);
    end
    tests_run++;
    if (dbg_cnt !== e.dbg_pulses) begin
      tests_failed++;
      $display("FAIL reset_dbg: %0d pulses, want %0d", dbg_cnt, e.dbg_pulses);
    end
  endtask

  // Sends pre-queued stimulus, then checks dbg count and steady-state duties
  task automatic run_and_check(input string name, input logic [63:0] f, input int nf,
                               input int expd, input logic [3:0][7:0] duty);
    exp_t e;
    int   d0;
    e.dbg_pulses = expd; e.duty = duty;
    sb.push_back(e);
    d0 = dbg_cnt;
    for (int r = 0; r < nf; r++) send_frame(f);
    repeat (270) @(posedge clk12);
    measure(256);
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_scoreboard: queue empty", name);
    end else begin
      e = sb.pop_front();
      if (dbg_cnt - d0 !== e.dbg_pulses) begin
        tests_failed++;
        $display("FAIL %s_dbg: %0d pulses, want %0d", name, dbg_cnt - d0, e.dbg_pulses);
      end
      for (int c = 0; c < 4; c++) begin
        tests_run++;
        if (hi_cnt[c] !== int'(e.duty[c])) begin
          tests_failed++;
          $display("FAIL %s_duty_ch%0d: high %0d of 256, want %0d", name, c, hi_cnt[c], e.duty[c]);
        end
        tests_run++;
        if (pwr_smp[c] !== (e.duty[c] != 8'd0)) begin
          tests_failed++;
          $display("FAIL %s_pwr_ch%0d: got %b want %b", name, c, pwr_smp[c], e.duty[c] != 8'd0);
        end
      end
    end
  endtask

  task automatic test_valid_frame();
    run_and_check("valid", 64'h55_00_24_00_FF_00_00_A4, 1, 1, {8'h00, 8'hFF, 8'h00, 8'h24});
  endtask

  task automatic test_update_red();
    run_and_check("red23", 64'h55_00_23_00_FF_00_00_A4, 1, 1, {8'h00, 8'hFF, 8'h00, 8'h23});
  endtask

  task automatic test_bad_trailer();
    run_and_check("bad_trailer", 64'h55_00_10_20_30_40_00_A5, 1, 0, {8'h00, 8'hFF, 8'h00, 8'h23});
  endtask

  task automatic test_partial_byte();
    send_bits(8'h55, 8);
    send_bits(8'h00, 8);
    send_bits(8'h99, 4);
    run_and_check("partial", 64'h55_00_40_11_80_22_00_A4, 1, 1, {8'h22, 8'h80, 8'h11, 8'h40});
  endtask

  task automatic test_no_sync();
    run_and_check("no_sync", 64'h00_24_11_22_33_44_00_A4, 1, 0, {8'h22, 8'h80, 8'h11, 8'h40});
    send_bits(8'h00, 8);
    send_bits(8'h24, 8);
    run_and_check("sync_after", 64'h55_00_00_07_00_01_00_A4, 1, 1, {8'h01, 8'h00, 8'h07, 8'h00});
  endtask

  task automatic test_back_to_back();
    run_and_check("b2b", 64'h55_01_FF_80_01_FE_33_A4, 2, 2, {8'hFE, 8'h01, 8'h80, 8'hFF});
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_update_red();
    test_bad_trailer();
    test_partial_byte();
    test_no_sync();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
